// File: rtl/case_mul_pkg.sv
// ---------------------------------------------------------------------------
// case_mul_pkg
//
// Purpose : shared constants and helper functions for the pipelined,
//           handshaked HLS multiplier (case_1_mul_pipe_hs) and its stage
//           register (case_mul_pipe_stage).
//
// Contents:
//   MAX_NUM_STAGE - deepest pipeline the core is intended to be built with
//   prodWidth()   - width of the full, lossless product of two operands
//   satHi()       - largest value representable in a result of given width
//   satLo()       - smallest value representable in a result of given width
//
// The saturation helpers are only referenced when the core is built with
// CASE_MUL_PIPE_SAT_EN defined.
// ---------------------------------------------------------------------------
package case_mul_pkg;

    localparam int MAX_NUM_STAGE = 8;

    // A signed x signed or unsigned x unsigned product never needs more
    // bits than the sum of the operand widths (even min x min fits).
    function automatic int prodWidth(input int aWidth, input int bWidth);
        return aWidth + bWidth;
    endfunction

    // Upper clamp bound for a result of 'width' bits.
    function automatic logic signed [63:0] satHi(input int width, input bit isSigned);
        if (isSigned) begin
            return (64'sd1 <<< (width - 1)) - 64'sd1;
        end
        return (64'sd1 <<< width) - 64'sd1;
    endfunction

    // Lower clamp bound for a result of 'width' bits.
    function automatic logic signed [63:0] satLo(input int width, input bit isSigned);
        if (isSigned) begin
            return -(64'sd1 <<< (width - 1));
        end
        return 64'sd0;
    endfunction

endpackage

// File: rtl/case_mul_pipe_stage.sv
// ---------------------------------------------------------------------------
// case_mul_pipe_stage
//
// Purpose : one valid-qualified data register of the multiplier pipeline.
//           The stage captures new contents whenever it is allowed to load,
//           which the parent derives as (!valid || next stage loads). When it
//           loads while its upstream neighbour is empty it simply becomes
//           empty itself, which is how bubbles collapse.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset (clears valid and data)
//   load_i   in   stage may replace its contents this cycle
//   valid_i  in   upstream data is valid
//   data_i   in   upstream data (WIDTH bits)
//   valid_o  out  this stage holds data
//   data_o   out  registered data (WIDTH bits)
// ---------------------------------------------------------------------------
module case_mul_pipe_stage
    import case_mul_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Data only changes when a valid item actually arrives, so an emptied
    // stage keeps its last value instead of toggling on garbage.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/case_1_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// case_1_mul_pipe_hs
//
// Purpose : pipelined multiplier with a valid/ready handshake on both sides
//           and full backpressure. Stage 0 captures the full product of the
//           accepted operand pair, intermediate stages carry it, and the last
//           stage captures the narrowed result. An item accepted in cycle t
//           is presented in cycle t+NUM_STAGE when nothing stalls; up to
//           NUM_STAGE results can be held while the output is blocked.
//
// Build option:
//   CASE_MUL_PIPE_SAT_EN  undefined: result is the product truncated (wraps)
//                         defined  : result is clamped to the dout range and
//                                    an extra 'sat' port flags clamped results
//
// Parameters:
//   ID          instance tag, no functional effect
//   NUM_STAGE   pipeline depth and latency, 1..8
//   din0_WIDTH  operand A width
//   din1_WIDTH  operand B width
//   dout_WIDTH  result width, 2..din0_WIDTH+din1_WIDTH
//   SIGNED      1: two's complement operands, 0: unsigned operands
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset; flushes the pipeline
//   in_valid   in   operand pair valid
//   in_ready   out  core accepts the operand pair this cycle
//   din0       in   operand A
//   din1       in   operand B
//   out_valid  out  dout holds a result
//   out_ready  in   downstream takes the result
//   dout       out  narrowed product
//   busy       out  at least one stage holds data
//   sat        out  (saturating build only) result was clamped
// ---------------------------------------------------------------------------
module case_1_mul_pipe_hs
    import case_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 7,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
`ifdef CASE_MUL_PIPE_SAT_EN
    output logic                  sat,
`endif
    output logic                  busy
);

    localparam int W = prodWidth(din0_WIDTH, din1_WIDTH);

`ifdef CASE_MUL_PIPE_SAT_EN
    // The last stage also carries the clamp flag above the result bits.
    localparam int TW = dout_WIDTH + 1;
    localparam logic signed [63:0] SAT_HI = satHi(dout_WIDTH, SIGNED != 0);
    localparam logic signed [63:0] SAT_LO = satLo(dout_WIDTH, SIGNED != 0);
`else
    localparam int TW = dout_WIDTH;
`endif

    logic                 inFire;
    logic [W-1:0]         prodFull;
    logic [W-1:0]         dChain [NUM_STAGE];
    logic [NUM_STAGE-1:0] stageValid;
    logic [NUM_STAGE-1:0] stageValidIn;
    logic [NUM_STAGE-1:0] stageLoad;
    logic [TW-1:0]        tailIn;
    logic [TW-1:0]        tailData;
    logic                 unusedSink;

    // Each operand is widened to the full product width before multiplying,
    // so the low W bits of the product are exact in both signedness modes.
    always_comb begin
        if (SIGNED != 0) begin
            prodFull = W'($signed(din0)) * W'($signed(din1));
        end else begin
            prodFull = W'(din0) * W'(din1);
        end
    end

    // Load enables are resolved tail-to-head in one block: a stage may load
    // if it is empty or if everything downstream of it is moving. A stalled
    // tail therefore still lets upstream stages fill any empty slot.
    always_comb begin
        stageLoad = '0;
        stageLoad[NUM_STAGE-1] = !stageValid[NUM_STAGE-1] || out_ready;
        for (int k = NUM_STAGE - 2; k >= 0; k--) begin
            stageLoad[k] = !stageValid[k] || stageLoad[k+1];
        end
    end

    // in_ready never looks at in_valid; it is forced low while in reset so
    // no transfer can be counted in a reset cycle.
    assign in_ready = stageLoad[0] && !reset;
    assign inFire   = in_valid && in_ready;

    always_comb begin
        stageValidIn    = '0;
        stageValidIn[0] = inFire;
        for (int k = 1; k < NUM_STAGE; k++) begin
            stageValidIn[k] = stageValid[k-1];
        end
    end

    assign dChain[0] = prodFull;

`ifdef CASE_MUL_PIPE_SAT_EN
    logic signed [63:0] pVal;

    // Extend the product according to signedness, then clamp it into the
    // dout range, setting the top bit of the tail word when clamping.
    always_comb begin
        pVal = 64'(dChain[NUM_STAGE-1]);
        if (SIGNED != 0) begin
            pVal = 64'($signed(dChain[NUM_STAGE-1]));
        end
        if (pVal > SAT_HI) begin
            tailIn = {1'b1, SAT_HI[dout_WIDTH-1:0]};
        end else if (pVal < SAT_LO) begin
            tailIn = {1'b1, SAT_LO[dout_WIDTH-1:0]};
        end else begin
            tailIn = {1'b0, pVal[dout_WIDTH-1:0]};
        end
    end
`else
    // Plain truncation: keep the low dout_WIDTH bits and let it wrap.
    always_comb begin
        tailIn = dChain[NUM_STAGE-1][dout_WIDTH-1:0];
    end
`endif

    // Stages 0..NUM_STAGE-2 carry the full product; the last stage holds
    // the narrowed result. With NUM_STAGE=1 the single stage is the tail and
    // narrows the freshly computed product directly.
    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        if (k < NUM_STAGE - 1) begin : g_carry
            case_mul_pipe_stage #(
                .WIDTH (W)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .load_i  (stageLoad[k]),
                .valid_i (stageValidIn[k]),
                .data_i  (dChain[k]),
                .valid_o (stageValid[k]),
                .data_o  (dChain[k+1])
            );
        end else begin : g_tail
            case_mul_pipe_stage #(
                .WIDTH (TW)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .load_i  (stageLoad[k]),
                .valid_i (stageValidIn[k]),
                .data_i  (tailIn),
                .valid_o (stageValid[k]),
                .data_o  (tailData)
            );
        end
    end

    // Outputs are also masked by reset so they read as idle for the whole
    // reset cycle, not only after the first reset edge.
    assign out_valid = stageValid[NUM_STAGE-1] && !reset;
    assign dout      = reset ? '0 : tailData[dout_WIDTH-1:0];
    assign busy      = (|stageValid) && !reset;

`ifdef CASE_MUL_PIPE_SAT_EN
    assign sat = tailData[dout_WIDTH] && stageValid[NUM_STAGE-1] && !reset;
`endif

    // Instance tag and product bits dropped by truncation have no function.
    assign unusedSink = (ID != 0) ^ (^dChain[NUM_STAGE-1]);

endmodule

// File: tb/tb_case_1_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// tb_case_1_mul_pipe_hs
//
// Directed and randomised bench for case_1_mul_pipe_hs. Instance A uses the
// default configuration (3 stages, signed); instance B is a 1-stage unsigned
// build. Expected results are produced from operands by a behavioural model
// and queued on acceptance, then compared in order when the DUT presents
// them. Honours CASE_MUL_PIPE_SAT_EN for the expected narrowing and 'sat'.
// ---------------------------------------------------------------------------
module tb_case_1_mul_pipe_hs;

    localparam int NA = 3;
    localparam int NB = 1;

    typedef struct packed {
        logic [6:0] d;
        logic       s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValidA, inReadyA, outValidA, outReadyA, busyA;
    logic [5:0] din0A, din1A;
    logic [6:0] doutA;
    logic       inValidB, inReadyB, outValidB, outReadyB, busyB;
    logic [5:0] din0B, din1B;
    logic [6:0] doutB;
`ifdef CASE_MUL_PIPE_SAT_EN
    logic       satA, satB;
`endif

    exp_t qA[$];
    exp_t qB[$];
    int   nCompared = 0;
    int   nMismatch = 0;
    bit   lastFire;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    case_1_mul_pipe_hs #(
        .ID(1), .NUM_STAGE(NA), .din0_WIDTH(6), .din1_WIDTH(6), .dout_WIDTH(7), .SIGNED(1)
    ) dutA (
        .clk(clk), .reset(reset), .in_valid(inValidA), .in_ready(inReadyA),
        .din0(din0A), .din1(din1A), .out_valid(outValidA), .out_ready(outReadyA),
        .dout(doutA),
`ifdef CASE_MUL_PIPE_SAT_EN
        .sat(satA),
`endif
        .busy(busyA)
    );

    case_1_mul_pipe_hs #(
        .ID(2), .NUM_STAGE(NB), .din0_WIDTH(6), .din1_WIDTH(6), .dout_WIDTH(7), .SIGNED(0)
    ) dutB (
        .clk(clk), .reset(reset), .in_valid(inValidB), .in_ready(inReadyB),
        .din0(din0B), .din1(din1B), .out_valid(outValidB), .out_ready(outReadyB),
        .dout(doutB),
`ifdef CASE_MUL_PIPE_SAT_EN
        .sat(satB),
`endif
        .busy(busyB)
    );

    // Single comparison point: counts, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural model of one result: exact integer product, then either
    // wrap to 7 bits or clamp into the 7-bit range.
    function automatic exp_t expectOut(input logic [5:0] a, input logic [5:0] b, input bit sgn);
        int          av, bv, p;
        logic [31:0] pBits;
        exp_t        e;
        if (sgn) begin
            av = $signed(a);
            bv = $signed(b);
        end else begin
            av = a;
            bv = b;
        end
        p     = av * bv;
        pBits = p;
        e.d   = pBits[6:0];
        e.s   = 1'b0;
`ifdef CASE_MUL_PIPE_SAT_EN
        begin
            int hi, lo;
            hi = sgn ? 63 : 127;
            lo = sgn ? -64 : 0;
            if (p > hi) begin
                pBits = hi;
                e.d   = pBits[6:0];
                e.s   = 1'b1;
            end else if (p < lo) begin
                pBits = lo;
                e.d   = pBits[6:0];
                e.s   = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    // Drives one cycle on instance A (selB=0) or B (selB=1) at the falling
    // edge, then checks ready/busy against occupancy, compares any presented
    // result with the queue head, and updates the scoreboard for the
    // transfers that will happen at the next rising edge.
    task automatic applyStimulus(input bit selB, input logic v, input logic [5:0] a,
                                 input logic [5:0] b, input logic ordy);
        logic  rdy, ov, bz, s;
        logic [6:0] d;
        int    n, depth;
        exp_t  head;
        string pre;
        @(negedge clk);
        if (selB) begin
            inValidB = v; din0B = a; din1B = b; outReadyB = ordy;
        end else begin
            inValidA = v; din0A = a; din1A = b; outReadyA = ordy;
        end
        #1;
        s = 1'b0;
        head = '0;
        if (selB) begin
            rdy = inReadyB; ov = outValidB; bz = busyB; d = doutB; n = qB.size(); depth = NB; pre = "B_";
            if (n != 0) head = qB[0];
`ifdef CASE_MUL_PIPE_SAT_EN
            s = satB;
`endif
        end else begin
            rdy = inReadyA; ov = outValidA; bz = busyA; d = doutA; n = qA.size(); depth = NA; pre = "A_";
            if (n != 0) head = qA[0];
`ifdef CASE_MUL_PIPE_SAT_EN
            s = satA;
`endif
        end
        checkOutput({pre, "in_ready"}, rdy, (n < depth) || ordy);
        checkOutput({pre, "busy"}, bz, n != 0);
        if (ov) begin
            if (n == 0) begin
                checkOutput({pre, "spurious_out_valid"}, ov, 1'b0);
            end else begin
                checkOutput({pre, "dout"}, d, head.d);
`ifdef CASE_MUL_PIPE_SAT_EN
                checkOutput({pre, "sat"}, s, head.s);
`endif
                if (ordy) begin
                    if (selB) void'(qB.pop_front());
                    else      void'(qA.pop_front());
                end
            end
        end
        lastFire = v && rdy;
        if (lastFire) begin
            if (selB) qB.push_back(expectOut(a, b, 1'b0));
            else      qA.push_back(expectOut(a, b, 1'b1));
        end
    endtask

    // Holds reset for nCycles rising edges with in_valid high on both
    // instances, checking that everything reads idle, then releases it and
    // checks in_ready comes straight back.
    task automatic pulseReset(input int nCycles);
        @(negedge clk);
        reset = 1'b1;
        inValidA = 1'b1; outReadyA = 1'b1;
        inValidB = 1'b1; outReadyB = 1'b1;
        #1;
        checkOutput("rst_in_ready_A", inReadyA, 1'b0);
        checkOutput("rst_in_ready_B", inReadyB, 1'b0);
        checkOutput("rst_out_valid_A", outValidA, 1'b0);
        repeat (nCycles) begin
            @(posedge clk);
            #1;
            checkOutput("rst_out_valid_A", outValidA, 1'b0);
            checkOutput("rst_out_valid_B", outValidB, 1'b0);
            checkOutput("rst_busy_A", busyA, 1'b0);
            checkOutput("rst_busy_B", busyB, 1'b0);
            checkOutput("rst_dout_A", doutA, 7'h00);
            checkOutput("rst_dout_B", doutB, 7'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        inValidA = 1'b0;
        inValidB = 1'b0;
        qA.delete();
        qB.delete();
        #1;
        checkOutput("post_rst_in_ready_A", inReadyA, 1'b1);
        checkOutput("post_rst_in_ready_B", inReadyB, 1'b1);
        checkOutput("post_rst_out_valid_A", outValidA, 1'b0);
        checkOutput("post_rst_busy_A", busyA, 1'b0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by the randomised runs.
    initial begin
        int         sent;
        logic [5:0] opA, opB;

        reset = 1'b1;
        inValidA = 1'b0; din0A = '0; din1A = '0; outReadyA = 1'b1;
        inValidB = 1'b0; din0B = '0; din1B = '0; outReadyB = 1'b1;
        lastFire = 1'b0;

        pulseReset(2);

        // 5 x -3 = -15 -> 7'h71, three cycles after acceptance.
        applyStimulus(1'b0, 1'b1, 6'd5, 6'h3D, 1'b1);
        checkOutput("t1_accept", lastFire, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        checkOutput("t1_lat_c1", outValidA, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        checkOutput("t1_lat_c2", outValidA, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        checkOutput("t1_lat_c3", outValidA, 1'b1);
        checkOutput("t1_dout", doutA, 7'h71);

        // -32 x -32 = 1024: wraps to 0, or clamps to 63.
        applyStimulus(1'b0, 1'b1, 6'h20, 6'h20, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
        checkOutput("t2_valid", outValidA, 1'b1);
`ifdef CASE_MUL_PIPE_SAT_EN
        checkOutput("t2_dout", doutA, 7'd63);
        checkOutput("t2_sat", satA, 1'b1);
`else
        checkOutput("t2_dout", doutA, 7'h00);
`endif

        // Unsigned 63 x 63 = 3969 on the 1-stage unsigned instance.
        applyStimulus(1'b1, 1'b1, 6'd63, 6'd63, 1'b1);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b1);
        checkOutput("t3_valid", outValidB, 1'b1);
`ifdef CASE_MUL_PIPE_SAT_EN
        checkOutput("t3_dout", doutB, 7'd127);
        checkOutput("t3_sat", satB, 1'b1);
`else
        checkOutput("t3_dout", doutB, 7'h01);
`endif

        // Ten random pairs back-to-back with the output blocked in cycles
        // 4..9; unaccepted operands are held until taken.
        sent = 0;
        opA  = 6'($urandom);
        opB  = 6'($urandom);
        for (int c = 0; c < 60 && (sent < 10 || qA.size() != 0); c++) begin
            applyStimulus(1'b0, sent < 10, opA, opB, !(c >= 4 && c <= 9));
            if (lastFire) begin
                sent++;
                opA = 6'($urandom);
                opB = 6'($urandom);
            end
        end
        checkOutput("t4_all_sent", sent, 10);
        checkOutput("t4_drained", qA.size(), 0);

        // Three results in flight behind a blocked output, then reset.
        applyStimulus(1'b0, 1'b1, 6'd7, 6'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'h3F, 6'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd11, 6'h30, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("t5_full_in_ready", inReadyA, 1'b0);
        pulseReset(1);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
            checkOutput("t5_no_stale", outValidA, 1'b0);
        end

        // Random valid/ready at 50% on the single-stage instance.
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'b1, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        end
        for (int c = 0; c < 20 && qB.size() != 0; c++) begin
            applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b1);
        end
        checkOutput("t6_drained", qB.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
